// File: rtl/line_bus_bridge_pkg.sv
// Shared types and constants for the cache-line to memory-bus bridge.
package line_bus_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_HDR,
    ST_WR_DATA,
    ST_WR_DONE,
    ST_RD_HDR,
    ST_RD_DATA,
    ST_RD_DONE
  } state_e;

  localparam logic REQTAG_WRITE = 1'b1;
  localparam logic REQTAG_READ  = 1'b0;

  function automatic int beats_of(input int line_w, input int bus_w);
    return line_w / bus_w;
  endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// One cache line of storage: whole-line load, beat-indexed write and beat-indexed read.
module line_beat_buffer
  import line_bus_bridge_pkg::*;
#(
  parameter int LINE_W    = 1024,
  parameter int BUS_WIDTH = 64,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load_en,
  input  logic [LINE_W-1:0]    load_line,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [BUS_WIDTH-1:0] wr_beat,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [BUS_WIDTH-1:0] rd_beat,
  output logic [LINE_W-1:0]    line
);

  logic [LINE_W-1:0] line_q;

  // NOTE: non-blocking assignments so every flop samples pre-edge values. The line is plain
  // flops, not a RAM, so it is reset: the fill output must read all-zero out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_q <= '0;
    end else if (load_en) begin
      line_q <= load_line;
    end else if (wr_en) begin
      line_q[wr_idx*BUS_WIDTH +: BUS_WIDTH] <= wr_beat;
    end
  end

  assign rd_beat = line_q[rd_idx*BUS_WIDTH +: BUS_WIDTH];
  assign line    = line_q;

endmodule

// File: rtl/line_bus_bridge.sv
// Converts whole-line cache fills/writebacks into header+beat memory bursts, one in flight.
// Optional snoop forwarding is enabled with the LINE_BUS_BRIDGE_SNOOP_EN macro.
module line_bus_bridge
  import line_bus_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int OFFSET_LENGTH = 4,
  parameter int BUS_WIDTH     = 64,
  parameter int REQTAG_WIDTH  = 8,
  localparam int LINE_W       = DATA_WIDTH * (2 ** OFFSET_LENGTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    command_valid,
  input  logic                    command_store,
  input  logic                    command_rready,
  input  logic [ADDR_WIDTH-1:0]   command_addr,
  input  logic [LINE_W-1:0]       data_to_bus,
  output logic [LINE_W-1:0]       data_from_bus,
  output logic                    bus_valid,
  output logic                    bus_ready,
  output logic                    mem_reqcyc,
  output logic [BUS_WIDTH-1:0]    mem_req,
  output logic [REQTAG_WIDTH-1:0] mem_reqtag,
  input  logic                    mem_reqack,
  input  logic                    mem_respcyc,
  input  logic [BUS_WIDTH-1:0]    mem_resp,
  output logic                    mem_respack,
`ifdef LINE_BUS_BRIDGE_SNOOP_EN
  input  logic                    mem_snoop_valid,
  input  logic [ADDR_WIDTH-1:0]   mem_snoop_addr,
`endif
  output logic                    invalidate,
  output logic [ADDR_WIDTH-1:0]   invalidate_addr
);

  localparam int BEATS = beats_of(LINE_W, BUS_WIDTH);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_LENGTH;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   cmd_line_addr;
  logic [LINE_W-1:0]       fill_hold_q;
  logic [LINE_W-1:0]       line;
  logic [BUS_WIDTH-1:0]    rd_beat;
  logic                    addr_load, buf_load, buf_wr;
  logic                    force_fill, fill_start;

  assign cmd_line_addr = command_addr & LINE_MASK;
  assign fill_start    = (state_q == ST_IDLE) && command_valid && !command_store &&
                         (command_rready || force_fill);

  line_beat_buffer #(
    .LINE_W    (LINE_W),
    .BUS_WIDTH (BUS_WIDTH),
    .IDX_W     (CNT_W)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_en   (buf_load),
    .load_line (data_to_bus),
    .wr_en     (buf_wr),
    .wr_idx    (cnt_q),
    .wr_beat   (mem_resp),
    .rd_idx    (cnt_q),
    .rd_beat   (rd_beat),
    .line      (line)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      fill_hold_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (addr_load) addr_q <= cmd_line_addr;
      if (state_q == ST_RD_DONE) fill_hold_q <= line;
    end
  end

  // The assembled line is presented straight from the buffer in RD_DONE, then held here.
  assign data_from_bus = (state_q == ST_RD_DONE) ? line : fill_hold_q;

  // NOTE: every signal written below gets a default first, so no path through the case
  // leaves one unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_load   = 1'b0;
    buf_load    = 1'b0;
    buf_wr      = 1'b0;
    mem_reqcyc  = 1'b0;
    mem_req     = '0;
    mem_reqtag  = '0;
    mem_respack = 1'b0;
    bus_valid   = 1'b0;
    bus_ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (command_valid && command_store) begin
          addr_load = 1'b1;
          buf_load  = 1'b1;
          state_d   = ST_WR_HDR;
        end else if (fill_start) begin
          addr_load = 1'b1;
          state_d   = ST_RD_HDR;
        end
      end
      ST_WR_HDR, ST_RD_HDR: begin
        mem_reqcyc = 1'b1;
        mem_req    = BUS_WIDTH'(addr_q);
        mem_reqtag[REQTAG_WIDTH-1] = (state_q == ST_WR_HDR) ? REQTAG_WRITE : REQTAG_READ;
        if (mem_reqack) begin
          cnt_d   = '0;
          state_d = (state_q == ST_WR_HDR) ? ST_WR_DATA : ST_RD_DATA;
        end
      end
      ST_WR_DATA: begin
        mem_reqcyc = 1'b1;
        mem_req    = rd_beat;
        if (mem_reqack) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = ST_WR_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_RD_DATA: begin
        mem_respack = mem_respcyc;
        buf_wr      = mem_respcyc;
        if (mem_respcyc) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = ST_RD_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WR_DONE: begin
        bus_ready = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_RD_DONE: begin
        bus_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef LINE_BUS_BRIDGE_SNOOP_EN
  logic                  refill_pend_q;
  logic [ADDR_WIDTH-1:0] refill_addr_q;
  logic                  snoop_hit;

  // A snoop landing on the line being filled poisons it; the cache's re-request must go out.
  assign snoop_hit  = mem_snoop_valid && ((mem_snoop_addr & LINE_MASK) == addr_q) &&
                      ((state_q == ST_RD_DATA) || (state_q == ST_RD_DONE));
  assign force_fill = refill_pend_q && (cmd_line_addr == refill_addr_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      invalidate      <= 1'b0;
      invalidate_addr <= '0;
      refill_pend_q   <= 1'b0;
      refill_addr_q   <= '0;
    end else begin
      invalidate      <= mem_snoop_valid;
      invalidate_addr <= mem_snoop_valid ? mem_snoop_addr : '0;
      if (snoop_hit) begin
        refill_pend_q <= 1'b1;
        refill_addr_q <= addr_q;
      end else if (fill_start && force_fill) begin
        refill_pend_q <= 1'b0;
      end
    end
  end
`else
  assign force_fill      = 1'b0;
  assign invalidate      = 1'b0;
  assign invalidate_addr = '0;
`endif

endmodule

// File: tb/tb_line_bus_bridge.sv
// Scoreboard bench for line_bus_bridge: memory model plus completion monitor against queued commands.
module tb_line_bus_bridge;

  localparam int AW = 64, BW = 64, TW = 8, BEATS = 16, LINE_W = 1024;
  localparam logic [63:0] LINE_MASK = ~64'hF;

  typedef struct {
    bit              wr;
    logic [63:0]     addr;
    logic [LINE_W-1:0] line;
  } txn_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              command_valid = 1'b0, command_store = 1'b0, command_rready = 1'b1;
  logic [AW-1:0]     command_addr = '0;
  logic [LINE_W-1:0] data_to_bus = '0;
  logic [LINE_W-1:0] data_from_bus;
  logic              bus_valid, bus_ready, mem_reqcyc, mem_respack;
  logic [BW-1:0]     mem_req;
  logic [TW-1:0]     mem_reqtag;
  logic              mem_reqack = 1'b0, mem_respcyc = 1'b0;
  logic [BW-1:0]     mem_resp = '0;
  logic              invalidate;
  logic [AW-1:0]     invalidate_addr;
`ifdef LINE_BUS_BRIDGE_SNOOP_EN
  logic              mem_snoop_valid = 1'b0;
  logic [AW-1:0]     mem_snoop_addr = '0;
`endif

  line_bus_bridge dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .command_valid   (command_valid),
    .command_store   (command_store),
    .command_rready  (command_rready),
    .command_addr    (command_addr),
    .data_to_bus     (data_to_bus),
    .data_from_bus   (data_from_bus),
    .bus_valid       (bus_valid),
    .bus_ready       (bus_ready),
    .mem_reqcyc      (mem_reqcyc),
    .mem_req         (mem_req),
    .mem_reqtag      (mem_reqtag),
    .mem_reqack      (mem_reqack),
    .mem_respcyc     (mem_respcyc),
    .mem_resp        (mem_resp),
    .mem_respack     (mem_respack),
`ifdef LINE_BUS_BRIDGE_SNOOP_EN
    .mem_snoop_valid (mem_snoop_valid),
    .mem_snoop_addr  (mem_snoop_addr),
`endif
    .invalidate      (invalidate),
    .invalidate_addr (invalidate_addr)
  );

  always #5 clk = ~clk;

  int   n_tests = 0, n_fail = 0;
  txn_t exp_q[$];
  bit   rand_mem = 1'b0;
  int   phase = 0;          // memory side: 0 expect header, 1 write beats, 2 read beats
  int   beat_idx = 0;
  int   stall_beat = -1, stall_left = 0;
  logic [LINE_W-1:0] last_fill = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [LINE_W-1:0] act,
                            input logic [LINE_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      for (int w = 0; w < BEATS; w++) begin
        if (act[w*BW +: BW] !== exp[w*BW +: BW]) begin
          $display("FAIL %s: word %0d got %0h expected %0h", name, w,
                   act[w*BW +: BW], exp[w*BW +: BW]);
          break;
        end
      end
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int w = 0; w < LINE_W / 32; w++) l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic issue(input bit wr, input logic [63:0] addr, input logic [LINE_W-1:0] line);
    txn_t t;
    t.wr = wr; t.addr = addr & LINE_MASK; t.line = line;
    exp_q.push_back(t);
    command_valid = 1'b1;
    command_store = wr;
    command_addr  = addr;
    data_to_bus   = wr ? line : ~line;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus_valid || bus_ready) begin
        lat = i + 1;
        break;
      end
    end
    if (lat < 0) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle_gap(input int n);
    command_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Memory side: acks request beats, checks header/write beats, serves fill beats.
  initial begin
    bit          in_rd, ack, drive, prev_stall;
    logic [63:0] prev_req;
    prev_stall = 1'b0;
    prev_req   = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        phase = 0; beat_idx = 0; prev_stall = 1'b0; stall_left = 0;
        mem_reqack = 1'b0; mem_respcyc = 1'b0;
        continue;
      end
      in_rd = (phase == 2);
      if (prev_stall && mem_reqcyc) check("req_stable", mem_req, prev_req);
      ack = mem_reqcyc && (rand_mem ? ($urandom_range(3) != 0) : 1'b1);
      if (ack && phase == 1 && beat_idx == stall_beat && stall_left > 0) begin
        ack = 1'b0;
        stall_left--;
      end
      mem_reqack = ack;
      if (ack) begin
        if (exp_q.size() == 0) begin
          check("req_without_cmd", 64'd1, 64'd0);
        end else if (phase == 0) begin
          check("hdr_addr", mem_req, exp_q[0].addr);
          check("hdr_tag", 64'(mem_reqtag), 64'({exp_q[0].wr, 7'b0}));
          phase    = exp_q[0].wr ? 1 : 2;
          beat_idx = 0;
        end else if (phase == 1) begin
          check("wr_beat", mem_req, exp_q[0].line[beat_idx*BW +: BW]);
          beat_idx++;
          if (beat_idx == BEATS) phase = 0;
        end else begin
          check("req_in_read", 64'd1, 64'd0);
        end
      end
      prev_stall = mem_reqcyc && !ack;
      prev_req   = mem_req;
      if (in_rd && exp_q.size() > 0) begin
        drive       = rand_mem ? ($urandom_range(3) != 0) : 1'b1;
        mem_respcyc = drive;
        mem_resp    = exp_q[0].line[beat_idx*BW +: BW];
      end else begin
        in_rd       = 1'b0;
        drive       = rand_mem && ($urandom_range(3) == 0);
        mem_respcyc = drive;
        mem_resp    = {$urandom, $urandom};
      end
      #1;
      check("respack", 64'(mem_respack), 64'(in_rd && drive));
      if (in_rd && drive && mem_respack) begin
        beat_idx++;
        if (beat_idx == BEATS) phase = 0;
      end
    end
  end

  // Completion monitor: pops the scoreboard on every bus_valid / bus_ready pulse.
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        last_fill = '0;
        continue;
      end
      if (bus_valid || bus_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          t = exp_q.pop_front();
          check("done_kind", 64'({bus_valid, bus_ready}), t.wr ? 64'd1 : 64'd2);
          if (!t.wr) last_fill = t.line;
        end
      end
      check_line("fill_line", data_from_bus, last_fill);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    logic [LINE_W-1:0] l;
    int lat, lat2, pulses;
    bit b2b;

    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({|data_from_bus, bus_valid, bus_ready, mem_reqcyc, |mem_req,
                                |mem_reqtag, mem_respack, invalidate, |invalidate_addr}), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fill with word k = A000+k, no stalls.
    for (int k = 0; k < BEATS; k++) l[k*BW +: BW] = 64'hA000 + k;
    issue(1'b0, 64'h2000, l);
    wait_done(lat);
    check("fill_latency", 64'(lat), 64'd18);
    idle_gap(2);

    // Writeback of word k = k at an unaligned address.
    for (int k = 0; k < BEATS; k++) l[k*BW +: BW] = 64'(k);
    issue(1'b1, 64'h1237, l);
    wait_done(lat);
    check("wb_latency", 64'(lat), 64'd18);
    idle_gap(2);

    // Three-cycle ack stall at write beat 5.
    stall_beat = 5; stall_left = 3;
    issue(1'b1, 64'h5550, rand_line());
    wait_done(lat);
    check("wb_stall_latency", 64'(lat), 64'd21);
    check("stall_consumed", 64'(stall_left), 64'd0);
    stall_beat = -1;
    idle_gap(2);

    // Fill then writeback raised on the bus_valid pulse.
    issue(1'b0, 64'h3000, rand_line());
    wait_done(lat);
    issue(1'b1, 64'h4008, rand_line());
    wait_done(lat2);
    check("b2b_wb_latency", 64'(lat2), 64'd19);
    idle_gap(2);

    // Fill held off while command_rready is low.
    command_rready = 1'b0;
    issue(1'b0, 64'h6000, rand_line());
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rready_gate", 64'(mem_reqcyc), 64'd0);
    end
    command_rready = 1'b1;
    wait_done(lat);
    check("rready_latency", 64'(lat), 64'd18);
    idle_gap(2);

    // Reset in the middle of a fill.
    issue(1'b0, 64'h7000, rand_line());
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #2;
      if (phase == 2 && beat_idx == 5) break;
    end
    check("reached_beat5", 64'(beat_idx), 64'd5);
    reset_n = 1'b0;
    command_valid = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_outputs", 64'({|data_from_bus, bus_valid, bus_ready, mem_reqcyc, |mem_req,
                                   |mem_reqtag, mem_respack, invalidate, |invalidate_addr}), 64'd0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus_valid || bus_ready) pulses++;
    end
    check("no_done_after_reset", 64'(pulses), 64'd0);
    issue(1'b0, 64'h7000, rand_line());
    wait_done(lat);
    check("post_reset_fill_latency", 64'(lat), 64'd18);
    idle_gap(2);

`ifdef LINE_BUS_BRIDGE_SNOOP_EN
    mem_snoop_valid = 1'b1; mem_snoop_addr = 64'h40;
    @(negedge clk);
    mem_snoop_valid = 1'b0; mem_snoop_addr = '0;
    check("snoop_inv", 64'(invalidate), 64'd1);
    check("snoop_addr", invalidate_addr, 64'h40);
    @(negedge clk);
    check("snoop_inv_drop", 64'(invalidate), 64'd0);
`endif

    // Randomized traffic with memory stalls, gaps and stray response beats.
    rand_mem = 1'b1;
    b2b = 1'b0;
    for (int t = 0; t < 40; t++) begin
      bit wr;
      wr = 1'(($urandom_range(1)));
      if (!wr && $urandom_range(3) == 0) begin
        command_rready = 1'b0;
        issue(1'b0, {$urandom, $urandom}, rand_line());
        repeat ($urandom_range(4, 1)) begin
          @(negedge clk);
          check("rand_rready_gate", 64'(mem_reqcyc), 64'd0);
        end
        command_rready = 1'b1;
      end else begin
        issue(wr, {$urandom, $urandom}, rand_line());
      end
      wait_done(lat);
      b2b = ($urandom_range(2) == 0);
      if (!b2b) idle_gap($urandom_range(3));
    end
    idle_gap(4);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
